// File: rtl/mux2_burst_arbiter_pkg.sv
// Shared definitions for the two-requester burst arbiter: state encoding,
// default parameters and the beat counter width helper.
package mux2_burst_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam int DW_DEF        = 8;
    localparam int MAX_BURST_DEF = 4;

    // Counter must be able to hold MAX_BURST itself.
    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/mux2_out_reg.sv
// Select-driven 2:1 data mux feeding a single registered output beat with
// valid/ready drain logic.
module mux2_out_reg
    import mux2_burst_arbiter_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic          load,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic          dout_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid
);

    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;

    // A load wins over a drain, so accept and drain together keep valid high.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        if (load) begin
            dout_d  = sel ? din1 : din0;
            valid_d = 1'b1;
        end else if (dout_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;

endmodule

// File: rtl/mux2_burst_arbiter.sv
// Round-robin burst arbiter: holds a grant for one burst (last beat,
// MAX_BURST beats or request withdrawal) and steers the shared output stage.
module mux2_burst_arbiter
    import mux2_burst_arbiter_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          last0,
    input  logic [DW-1:0] din0,
    output logic          ready0,
    input  logic          req1,
    input  logic          last1,
    input  logic [DW-1:0] din1,
    output logic          ready1,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          sel,
    output logic          busy
);

    localparam int CW = cnt_w(MAX_BURST);

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          sel_q, sel_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          space, acc, acc_last;
    logic          own1, cur_req, oth_req, burst_end;

    assign space    = !dout_valid || dout_ready;
    assign ready0   = (state_q == GNT0) && req0 && space;
    assign ready1   = (state_q == GNT1) && req1 && space;
    assign acc      = ready0 || ready1;
    assign acc_last = ready1 ? last1 : last0;
    assign cnt_inc  = beat_cnt_q + 1'b1;
    assign own1     = (state_q == GNT1);
    assign cur_req  = own1 ? req1 : req0;
    assign oth_req  = own1 ? req0 : req1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        beat_cnt_d = beat_cnt_q;
        burst_end  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 && req1)  state_d = ptr_q ? GNT1 : GNT0;
                else if (req0)     state_d = GNT0;
                else if (req1)     state_d = GNT1;
            end
            GNT0, GNT1: begin
                burst_end = !cur_req ||
                            (acc && (acc_last || cnt_inc == CW'(MAX_BURST)));
                if (burst_end) begin
                    beat_cnt_d = '0;
                    ptr_d      = !own1;
                    // Hand over without a bubble; otherwise re-grant or idle.
                    if (oth_req)      state_d = own1 ? GNT0 : GNT1;
                    else if (cur_req) state_d = state_q;
                    else              state_d = IDLE;
                end else if (acc) begin
                    beat_cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == GNT0)      sel_d = 1'b0;
        else if (state_d == GNT1) sel_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            sel_q      <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign sel  = sel_q;
    assign busy = (state_q != IDLE);

    mux2_out_reg #(.DW(DW)) u_out (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel_q),
        .load       (acc),
        .din0       (din0),
        .din1       (din1),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

endmodule

// File: tb/tb_mux2_burst_arbiter.sv
// Bench for the burst arbiter: a grant-level reference model predicts
// handshakes each cycle and feeds a scoreboard checked by a separate monitor.
module tb_mux2_burst_arbiter;

    localparam int DW   = 8;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, last0 = 1'b0, req1 = 1'b0, last1 = 1'b0;
    logic [DW-1:0] din0 = '0, din1 = '0;
    logic          ready0, ready1, dout_valid, sel, busy;
    logic          dout_ready = 1'b0;
    logic [DW-1:0] dout;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_q[$];

    // Reference model: who owns the channel, beats taken, whose turn is next.
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_cnt   = 0;
    bit            m_valid = 1'b0;
    bit            m_sel   = 1'b0;
    logic [DW-1:0] m_dout  = '0;

    mux2_burst_arbiter #(.DW(DW), .MAX_BURST(MAXB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .last0      (last0),
        .din0       (din0),
        .ready0     (ready0),
        .req1       (req1),
        .last1      (last1),
        .din1       (din1),
        .ready1     (ready1),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sel        (sel),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r0, input bit l0, input logic [DW-1:0] d0,
                       input bit r1, input bit l1, input logic [DW-1:0] d1,
                       input bit rdy);
        @(posedge clk);
        #1;
        req0 = r0; last0 = l0; din0 = d0;
        req1 = r1; last1 = l1; din1 = d1;
        dout_ready = rdy;
    endtask

    // Model: compare this cycle's observable state, then advance one cycle.
    always @(negedge clk) begin
        bit space, e0, e1, rk, ro, lk, ended;
        int k;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
            m_valid = 1'b0; m_sel = 1'b0; m_dout = '0;
            exp_q.delete();
        end else begin
            space = !m_valid || dout_ready;
            e0 = (m_owner == 0) && req0 && space;
            e1 = (m_owner == 1) && req1 && space;
            chk("ready0", int'(ready0), int'(e0));
            chk("ready1", int'(ready1), int'(e1));
            chk("busy", int'(busy), int'(m_owner >= 0));
            chk("sel", int'(sel), int'(m_sel));
            chk("dout_valid", int'(dout_valid), int'(m_valid));
            if (m_valid) chk("dout_held", int'(dout), int'(m_dout));

            if (e0) begin exp_q.push_back(din0); m_dout = din0; end
            if (e1) begin exp_q.push_back(din1); m_dout = din1; end
            if (e0 || e1)        m_valid = 1'b1;
            else if (dout_ready) m_valid = 1'b0;

            if (m_owner < 0) begin
                if (req0 && req1) m_owner = m_ptr;
                else if (req0)    m_owner = 0;
                else if (req1)    m_owner = 1;
            end else begin
                k  = m_owner;
                rk = (k == 1) ? req1 : req0;
                ro = (k == 1) ? req0 : req1;
                lk = (k == 1) ? last1 : last0;
                ended = 1'b0;
                if (!rk) ended = 1'b1;
                else if (e0 || e1) begin
                    m_cnt++;
                    if (lk || m_cnt == MAXB) ended = 1'b1;
                end
                if (ended) begin
                    m_cnt   = 0;
                    m_ptr   = 1 - k;
                    m_owner = ro ? (1 - k) : (rk ? k : -1);
                end
            end
            if (m_owner >= 0) m_sel = m_owner[0];
        end
    end

    // Monitor: every beat the consumer takes must be the oldest expected one.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (!rst && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_dout", int'(dout), int'(e));
            end
        end
    end

    initial begin
        // Reset state while rst is held.
        repeat (2) @(posedge clk);
        #2;
        chk("rst_dout", int'(dout), 0);
        chk("rst_dout_valid", int'(dout_valid), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready0", int'(ready0), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single requester: A1, A2, A3 with last on A3.
        cyc(1, 0, 8'hA1, 0, 0, 8'h00, 1);
        cyc(1, 0, 8'hA1, 0, 0, 8'h00, 1);
        cyc(1, 0, 8'hA2, 0, 0, 8'h00, 1);
        cyc(1, 1, 8'hA3, 0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0, 0, 8'h00, 1);

        // Backpressure: 55 held for three stalled cycles, then drain and load.
        cyc(1, 1, 8'h55, 0, 0, 8'h00, 1);
        cyc(1, 1, 8'h55, 0, 0, 8'h00, 0);
        repeat (3) cyc(1, 1, 8'h66, 0, 0, 8'h00, 0);
        cyc(1, 1, 8'h66, 0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0, 0, 8'h00, 1);

        // MAX_BURST cut: requester 1 never signals last, requester 0 joins.
        cyc(0, 0, 8'h00, 1, 0, 8'hB0, 1);
        cyc(0, 0, 8'h00, 1, 0, 8'hB1, 1);
        cyc(1, 0, 8'hC0, 1, 0, 8'hB2, 1);
        cyc(1, 0, 8'hC0, 1, 0, 8'hB3, 1);
        cyc(1, 0, 8'hC0, 1, 0, 8'hB4, 1);
        cyc(1, 1, 8'hC0, 0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0, 0, 8'h00, 1);

        // Abort: requester 1 withdraws after one beat while requester 0 waits.
        cyc(0, 0, 8'h00, 1, 0, 8'hD1, 1);
        cyc(0, 0, 8'h00, 1, 0, 8'hD1, 1);
        cyc(1, 1, 8'hE1, 0, 0, 8'hD2, 1);
        cyc(1, 1, 8'hE1, 0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0, 0, 8'h00, 1);

        // Contention: both request continuously, last on alternate cycles.
        for (int i = 0; i < 16; i++)
            cyc(1, i[0], 8'(i), 1, i[0], 8'(8'h80 + i), 1);
        cyc(0, 0, 8'h00, 0, 0, 8'h00, 1);

        // Reset mid-burst inside GNT1 with a stalled beat on dout.
        cyc(0, 0, 8'h00, 1, 0, 8'h77, 0);
        cyc(0, 0, 8'h00, 1, 0, 8'h77, 0);
        cyc(0, 0, 8'h00, 1, 0, 8'h78, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_sel", int'(sel), 0);
        chk("async_rst_dout_valid", int'(dout_valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        req0 = 1'b1; last0 = 1'b1; din0 = 8'h01;
        req1 = 1'b1; last1 = 1'b1; din1 = 8'h02;
        dout_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 chk("post_rst_grant_sel", int'(sel), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 2) == 0, 8'($urandom),
                $urandom_range(0, 9) < 8, $urandom_range(0, 2) == 0, 8'($urandom),
                $urandom_range(0, 3) != 0);

        repeat (4) cyc(0, 0, 8'h00, 0, 0, 8'h00, 1);
        @(negedge clk);
        #1 chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
